mcdt_arbiter: RTL and testbench

- Output-side scheduler for the multi-channel data transfer path.
- Shares the single mcdt output port between NCH channel FIFOs, each first-word-fall-through.
- Grants one channel at a time for a programmable burst of beats, pops that FIFO and drives registered mcdt_data/val/id.
- Arbitration is round-robin or fixed-priority (ch0 highest), with a per-channel enable.

---
 rtl/mcdt_pkg.sv | 11 +
 rtl/mcdt_rr_pick.sv | 29 ++
 rtl/mcdt_arbiter.sv | 95 +++++++++
 tb/tb_mcdt_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcdt_pkg.sv
// Shared types and constants for the mcdt output-side scheduler.
package mcdt_pkg;
  typedef logic [1:0] chid_t;
  typedef enum logic {ARB, XFER} arb_state_e;

  localparam int MCDT_DW  = 32;
  localparam int MCDT_NCH = 3;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;
endpackage

// File: rtl/mcdt_rr_pick.sv
// Combinational channel picker: first eligible channel from a start index,
// rotating (round-robin) or pinned at 0 (fixed priority).
module mcdt_rr_pick
  import mcdt_pkg::*;
#(
  parameter int NCH = MCDT_NCH
) (
  input  logic [NCH-1:0] elig,
  input  chid_t          rr_ptr,
  input  logic           prio_mode,
  output chid_t          grant,
  output logic           any_elig
);
  always_comb begin
    int k;
    int start;
    grant    = '0;
    any_elig = 1'b0;
    k        = 0;
    start    = (prio_mode == PRIO_FIXED) ? 0 : int'(rr_ptr);
    for (int i = 0; i < NCH; i++) begin
      k = (start + i) % NCH;
      if (!any_elig && elig[k]) begin
        any_elig = 1'b1;
        grant    = chid_t'(k);
      end
    end
  end
endmodule

// File: rtl/mcdt_arbiter.sv
// Shares the mcdt output port between NCH FWFT channel FIFOs, granting one
// channel at a time for a burst and registering the popped beats.
module mcdt_arbiter
  import mcdt_pkg::*;
#(
  parameter int DW  = MCDT_DW,
  parameter int NCH = MCDT_NCH,
  parameter int BLW = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH*DW-1:0] data_i,
  input  logic [NCH-1:0]    en_i,
  input  logic              prio_mode_i,
  input  logic [BLW-1:0]    burst_len_i,
  output logic [NCH-1:0]    ack_o,
  output logic [DW-1:0]     mcdt_data_o,
  output logic              mcdt_val_o,
  output chid_t             mcdt_id_o,
  output logic              busy_o
);
  localparam logic [BLW:0] ONE = (BLW+1)'(1);

  arb_state_e     state, state_nx;
  chid_t          g, pick, rr_ptr;
  logic           any_elig, ack_any, last;
  logic [NCH-1:0] elig;
  logic [BLW:0]   count, blen;

  assign elig = req_i & en_i;

  mcdt_rr_pick #(.NCH(NCH)) u_pick (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .prio_mode (prio_mode_i),
    .grant     (pick),
    .any_elig  (any_elig)
  );

  // Pop only the granted channel, and only while it still has data and is enabled.
  assign ack_any = !rst_i && (state == XFER) && elig[g];
  assign last    = ack_any && ((count + ONE) == blen);
  assign busy_o  = (state == XFER);

  always_comb begin
    ack_o = '0;
    if (ack_any) ack_o[g] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB:     if (any_elig) state_nx = XFER;
      XFER:    if (!ack_any || last) state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ARB;
      g      <= '0;
      count  <= '0;
      blen   <= ONE;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB && any_elig) begin
        g     <= pick;
        blen  <= (burst_len_i == '0) ? ONE : {1'b0, burst_len_i};
        count <= '0;
      end else if (ack_any) begin
        count <= count + ONE;
      end
      // Pointer advances on every release, even in fixed-priority mode.
      if (state == XFER && state_nx == ARB)
        rr_ptr <= (g == chid_t'(NCH-1)) ? '0 : g + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcdt_val_o  <= 1'b0;
      mcdt_data_o <= '0;
      mcdt_id_o   <= '0;
    end else begin
      mcdt_val_o <= ack_any;
      if (ack_any) begin
        mcdt_data_o <= data_i[int'(g)*DW +: DW];
        mcdt_id_o   <= g;
      end
    end
  end
endmodule

// File: tb/tb_mcdt_arbiter.sv
// Bench for mcdt_arbiter: queue-based FIFOs, burst-countdown reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_mcdt_arbiter;
  localparam int DW = 32, NCH = 3, BLW = 3;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    req_i, en_i, ack_o;
  logic [NCH*DW-1:0] data_i;
  logic              prio_mode_i;
  logic [BLW-1:0]    burst_len_i;
  logic [DW-1:0]     mcdt_data_o;
  logic              mcdt_val_o;
  logic [1:0]        mcdt_id_o;
  logic              busy_o;

  always #5 clk = ~clk;

  mcdt_arbiter #(.DW(DW), .NCH(NCH), .BLW(BLW)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i), .en_i(en_i),
    .prio_mode_i(prio_mode_i), .burst_len_i(burst_len_i), .ack_o(ack_o),
    .mcdt_data_o(mcdt_data_o), .mcdt_val_o(mcdt_val_o), .mcdt_id_o(mcdt_id_o),
    .busy_o(busy_o)
  );

  // staged stimulus, applied to the DUT at the next falling edge
  logic           s_rst, s_prio;
  logic [NCH-1:0] s_en;
  logic [BLW-1:0] s_bl;

  logic [DW-1:0] q [NCH][$];

  // model: owner=-1 means arbitrating; left = beats still allowed in the burst
  int          m_owner, m_left, m_ptr, m_id;
  logic        m_val;
  logic [31:0] m_data;

  int             checks = 0, errors = 0, cyc = 0;
  bit             chk_en = 0;
  int             log_id[$], log_cyc[$];
  logic [31:0]    log_data[$];
  logic [NCH-1:0] last_ack;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [NCH-1:0] elig, exp_ack;
    int g, c;
    bit found;
    @(negedge clk);
    rst_i = s_rst; en_i = s_en; prio_mode_i = s_prio; burst_len_i = s_bl;
    for (int n = 0; n < NCH; n++) begin
      req_i[n] = (q[n].size() > 0);
      data_i[n*DW +: DW] = req_i[n] ? q[n][0] : '0;
    end
    #1;
    elig = req_i & en_i;
    exp_ack = '0;
    if (!s_rst && m_owner >= 0 && elig[m_owner]) exp_ack[m_owner] = 1'b1;
    if (chk_en) begin
      chk("ack", 64'(ack_o), 64'(exp_ack));
      chk("val", 64'(mcdt_val_o), 64'(m_val));
      chk("data", 64'(mcdt_data_o), 64'(m_data));
      chk("id", 64'(mcdt_id_o), 64'(m_id));
      chk("busy", 64'(busy_o), 64'(m_owner >= 0));
    end
    if (mcdt_val_o) begin
      log_id.push_back(int'(mcdt_id_o));
      log_data.push_back(mcdt_data_o);
      log_cyc.push_back(cyc);
    end
    last_ack = ack_o;
    if (s_rst) begin
      m_owner = -1; m_ptr = 0; m_val = 0; m_data = 0; m_id = 0;
    end else if (m_owner < 0) begin
      m_val = 0;
      found = 0;
      for (int i = 0; i < NCH; i++) begin
        c = s_prio ? i : (m_ptr + i) % NCH;
        if (!found && elig[c]) begin
          found = 1; m_owner = c;
          m_left = (s_bl == 0) ? 1 : int'(s_bl);
        end
      end
    end else begin
      g = m_owner;
      if (elig[g]) begin
        m_val = 1; m_data = q[g].pop_front(); m_id = g;
        m_left--;
        if (m_left == 0) begin m_owner = -1; m_ptr = (g + 1) % NCH; end
      end else begin
        m_val = 0; m_owner = -1; m_ptr = (g + 1) % NCH;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    log_id.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    for (int n = 0; n < NCH; n++) q[n].delete();
    s_rst = 1; run(2); s_rst = 0;
    clear_log();
  endtask

  task automatic wait_log(input string nm, input int n, input int budget);
    int k = 0;
    while (log_id.size() < n && k < budget) begin step(); k++; end
    chk(nm, 64'(log_id.size() >= n), 64'd1);
  endtask

  task automatic top_up(input int ch);
    if (q[ch].size() < 4) q[ch].push_back($urandom);
  endtask

  initial begin
    int e2[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    int e5[6] = '{0, 0, 1, 1, 1, 1};
    int k, n2;
    m_owner = -1; m_ptr = 0; m_val = 0; m_data = 0; m_id = 0; m_left = 0;
    s_rst = 1; s_en = '1; s_prio = 0; s_bl = 3'd4;
    step();
    chk_en = 1;
    step();
    chk("rst_val", 64'(mcdt_val_o), 64'd0);
    chk("rst_data", 64'(mcdt_data_o), 64'd0);
    chk("rst_id", 64'(mcdt_id_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ack", 64'(ack_o), 64'd0);

    // single channel, 4-beat bursts: 4 beats, bubble, repeat
    do_reset(); s_bl = 3'd4;
    for (int i = 0; i < 10; i++) q[1].push_back(32'h00C1_0000 + i);
    wait_log("t1_wait", 10, 60); run(5);
    chk("t1_count", 64'(log_id.size()), 64'd10);
    if (log_id.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("t1_data", 64'(log_data[i]), 64'(32'h00C1_0000 + i));
        chk("t1_id", 64'(log_id[i]), 64'd1);
      end
      chk("t1_span", 64'(log_cyc[9] - log_cyc[0] + 1), 64'd12);
    end

    // all three channels, round-robin, 2-beat bursts
    do_reset(); s_bl = 3'd2;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 6; i++) q[c].push_back(32'hA000_0000 | (c << 16) | i);
    wait_log("t2_wait", 18, 80);
    if (log_id.size() >= 8)
      for (int i = 0; i < 8; i++) chk("t2_order", 64'(log_id[i]), 64'(e2[i]));

    // burst_len 0 acts as single beats, alternating 0/2
    do_reset(); s_bl = 3'd0;
    for (int i = 0; i < 4; i++) begin q[0].push_back(32'h100 + i); q[2].push_back(32'h300 + i); end
    wait_log("t3_wait", 8, 60);
    if (log_id.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("t3_alt", 64'(log_id[i]), 64'((i % 2) * 2));
      chk("t3_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd2);
    end

    // fixed priority: ch2 starves while ch0 eligible; then drop en0 mid-burst
    do_reset(); s_prio = 1; s_bl = 3'd3;
    for (int i = 0; i < 30; i++) begin top_up(0); top_up(2); step(); end
    n2 = 0;
    foreach (log_id[i]) if (log_id[i] == 2) n2++;
    chk("t4_starve", 64'(n2), 64'd0);
    k = 0;
    do begin top_up(0); top_up(2); step(); k++; end
    while (!(busy_o && last_ack[0]) && k < 20);
    chk("t4_midburst", 64'(busy_o && last_ack[0]), 64'd1);
    s_en = 3'b110; top_up(2); step();
    chk("t4_noack", 64'(last_ack), 64'd0);
    clear_log();
    k = 0;
    while (log_id.size() < 1 && k < 10) begin top_up(2); step(); k++; end
    chk("t4_next", 64'(log_id.size() > 0 ? log_id[0] : 9), 64'd2);
    s_en = '1; s_prio = 0;

    // short FIFO releases early, next channel follows
    do_reset(); s_bl = 3'd4;
    for (int i = 0; i < 2; i++) q[0].push_back(32'h500 + i);
    for (int i = 0; i < 4; i++) q[1].push_back(32'h600 + i);
    wait_log("t5_wait", 6, 40);
    if (log_id.size() >= 6)
      for (int i = 0; i < 6; i++) chk("t5_order", 64'(log_id[i]), 64'(e5[i]));

    // reset after the 2nd beat of a 4-beat burst
    do_reset(); s_bl = 3'd4;
    for (int i = 0; i < 8; i++) q[0].push_back(32'h700 + i);
    for (int i = 0; i < 4; i++) q[2].push_back(32'h800 + i);
    wait_log("t6_wait", 2, 20);
    s_rst = 1; step();
    chk("t6_ack", 64'(last_ack), 64'd0);
    step();
    chk("t6_val", 64'(mcdt_val_o), 64'd0);
    s_rst = 0; clear_log();
    wait_log("t6_restart", 4, 20);
    if (log_id.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t6_ch0", 64'(log_id[i]), 64'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2) == 0) begin
        k = $urandom_range(NCH - 1);
        if (q[k].size() < 8) q[k].push_back($urandom);
      end
      for (int c = 0; c < NCH; c++) s_en[c] = ($urandom_range(99) < 85);
      if ($urandom_range(49) == 0) s_prio = ~s_prio;
      s_bl  = BLW'($urandom_range(7));
      s_rst = ($urandom_range(99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
